serial_sub_ctrl: RTL and testbench

- Bit-serial subtraction controller that computes a − b, LSB first, one bit per clock.
- Uses a single 1-bit subtraction cell, built from two half-subtraction stages plus a registered borrow.
- Handles operand capture, bit sequencing, borrow propagation, result assembly and the start/done handshake.
- Sits beside the combinational subtractor blocks as the area-minimal sequential alternative for wide operands.

---
 rtl/serial_sub_ctrl_pkg.sv | 24 ++
 rtl/serial_sub_ctrl_if.sv | 22 ++
 rtl/serial_sub_ctrl_cell.sv | 23 ++
 rtl/serial_sub_ctrl.sv | 140 ++++++++++++++
 tb/tb_serial_sub_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtraction controller:
// FSM state encoding and the bit-counter width helper.
package serial_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter width: enough bits to index positions 0..WIDTH-1.
  // Never narrower than one bit so the counter always exists.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Start/done handshake plus operand and result bus of the serial subtractor.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bor;

  modport master (
    output start, a, b,
    input  busy, done, diff, bor
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bor
  );
endinterface

// File: rtl/serial_sub_ctrl_cell.sv
// 1-bit full subtractor: two half-subtraction stages, borrows OR-ed.
// Computes d = a - b - bin and the borrow out of this bit position.
module serial_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1_s;
  logic b1_s;
  logic b2_s;

  // First half-subtraction: a - b
  assign d1_s = a ^ b;
  assign b1_s = ~a & b;

  // Second half-subtraction: (a - b) - bin
  assign d    = d1_s ^ bin;
  assign b2_s = ~d1_s & bin;

  assign bout = b1_s | b2_s;
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction controller: diff = a - b, LSB first, one bit per
// clock through a single full-subtractor cell with a registered borrow.
// A start accepted in IDLE or DONE gives WIDTH RUN cycles then one DONE cycle.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_sub_ctrl_if.slave  bus
);
  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_r;
  state_t             state_nxt_s;
  logic               accept_s;
  logic               last_s;

  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   diff_r;
  logic               borrow_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               bor_r;
  logic               busy_r;
  logic               done_r;

  logic               d_s;
  logic               bout_s;

  // The one subtraction cell works on the current LSBs of the operand shifters
  serial_sub_cell u_cell (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .bin  (borrow_r),
    .d    (d_s),
    .bout (bout_s)
  );

  // FSM state register; reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; start is only looked at in IDLE and DONE
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = (cnt_r == CNT_W'(WIDTH - 1));
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Operand capture, bit sequencing, borrow chain and result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      bor_r    <= 1'b0;
    end else if (accept_s) begin
      a_sh_r   <= bus.a;
      b_sh_r   <= bus.b;
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      bor_r    <= 1'b0;
    end else if (state_r == ST_RUN) begin
      // Each new bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB
      diff_r   <= {d_s, diff_r[WIDTH-1:1]};
      borrow_r <= bout_s;
      a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
      if (last_s) begin
        // Counter parks at its terminal value; the next accept clears it
        bor_r <= bout_s;
        cnt_r <= cnt_r;
      end else begin
        bor_r <= bor_r;
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      a_sh_r   <= a_sh_r;
      b_sh_r   <= b_sh_r;
      diff_r   <= diff_r;
      borrow_r <= borrow_r;
      cnt_r    <= cnt_r;
      bor_r    <= bor_r;
    end
  end

  // Status flags registered from the next state so they line up with state_r
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == ST_RUN);
      done_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.bor  = bor_r;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: vector table for single operations,
// plus hand-written sequences for ignored start, mid-run reset,
// back-to-back operation and a 16-bit build.
module tb_serial_sub_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  serial_sub_ctrl_if #(.WIDTH(8))  if8 ();
  serial_sub_ctrl_if #(.WIDTH(16)) if16 ();

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  serial_sub_ctrl #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_diff;
    logic       exp_bor;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Start one 8-bit operation and wait (bounded) for done.
  // lat = cycles after the accept edge until done is seen (expected 8).
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int busy_cnt);
    @(negedge clk);
    if8.start = 1'b1;
    if8.a     = a;
    if8.b     = b;
    @(negedge clk);
    if8.start = 1'b0;
    if8.a     = ~a;
    if8.b     = ~b;
    lat      = 0;
    busy_cnt = 0;
    while (!if8.done && lat < 40) begin
      if (if8.busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int done_cnt;
    int first_done;
    int td [2];
    logic [7:0] rd [2];
    logic       rb [2];
    int n;
    int t;
    logic [7:0] first_diff;

    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{a: 8'd25,   b: 8'd10,   exp_diff: 8'h0F, exp_bor: 1'b0};
    vecs[1] = '{a: 8'd10,   b: 8'd25,   exp_diff: 8'hF1, exp_bor: 1'b1};
    vecs[2] = '{a: 8'd0,    b: 8'd0,    exp_diff: 8'h00, exp_bor: 1'b0};
    vecs[3] = '{a: 8'h00,   b: 8'h01,   exp_diff: 8'hFF, exp_bor: 1'b1};
    vecs[4] = '{a: 8'h80,   b: 8'h7F,   exp_diff: 8'h01, exp_bor: 1'b0};
    vecs[5] = '{a: 8'hFF,   b: 8'hFF,   exp_diff: 8'h00, exp_bor: 1'b0};

    rst       = 1'b1;
    if8.start = 1'b0;
    if8.a     = 8'h00;
    if8.b     = 8'h00;
    if16.start = 1'b0;
    if16.a     = 16'h0000;
    if16.b     = 16'h0000;
    repeat (3) @(negedge clk);

    check("reset_busy", {31'd0, if8.busy}, 32'd0);
    check("reset_done", {31'd0, if8.done}, 32'd0);
    check("reset_diff", {24'd0, if8.diff}, 32'd0);
    check("reset_bor",  {31'd0, if8.bor},  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single operations
    for (int i = 0; i < 6; i++) begin
      run_op8(vecs[i].a, vecs[i].b, lat, busy_cnt);
      check($sformatf("vec%0d_latency", i), lat, 32'd8);
      check($sformatf("vec%0d_busy_cycles", i), busy_cnt, 32'd8);
      check($sformatf("vec%0d_diff", i), {24'd0, if8.diff}, {24'd0, vecs[i].exp_diff});
      check($sformatf("vec%0d_bor", i), {31'd0, if8.bor}, {31'd0, vecs[i].exp_bor});
      @(negedge clk);
      check($sformatf("vec%0d_done_one_cycle", i), {31'd0, if8.done}, 32'd0);
      check($sformatf("vec%0d_diff_hold", i), {24'd0, if8.diff}, {24'd0, vecs[i].exp_diff});
      check($sformatf("vec%0d_bor_hold", i), {31'd0, if8.bor}, {31'd0, vecs[i].exp_bor});
    end

    // Start during RUN (third busy cycle) is ignored
    @(negedge clk);
    if8.start = 1'b1;
    if8.a     = 8'd25;
    if8.b     = 8'd10;
    @(negedge clk);
    if8.start  = 1'b0;
    done_cnt   = 0;
    first_done = -1;
    first_diff = 8'h00;
    for (int j = 0; j < 20; j++) begin
      if (j == 2) begin
        if8.start = 1'b1;
        if8.a     = 8'hFF;
        if8.b     = 8'h01;
      end else begin
        if8.start = 1'b0;
      end
      if (if8.done) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = j;
          first_diff = if8.diff;
        end
      end
      @(negedge clk);
    end
    check("ign_done_count", done_cnt, 32'd1);
    check("ign_done_latency", first_done, 32'd8);
    check("ign_diff_at_done", {24'd0, first_diff}, 32'h0F);
    check("ign_diff_after", {24'd0, if8.diff}, 32'h0F);
    check("ign_busy_after", {31'd0, if8.busy}, 32'd0);

    // Reset in the fourth busy cycle aborts the operation
    if8.start = 1'b1;
    if8.a     = 8'd25;
    if8.b     = 8'd10;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before_rst", {31'd0, if8.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {31'd0, if8.busy}, 32'd0);
    check("rst_done", {31'd0, if8.done}, 32'd0);
    check("rst_diff", {24'd0, if8.diff}, 32'd0);
    check("rst_bor",  {31'd0, if8.bor},  32'd0);
    run_op8(8'd200, 8'd100, lat, busy_cnt);
    check("post_rst_latency", lat, 32'd8);
    check("post_rst_diff", {24'd0, if8.diff}, 32'h64);
    check("post_rst_bor",  {31'd0, if8.bor},  32'd0);
    @(negedge clk);

    // Back-to-back: start held high, operands changed after first accept
    @(negedge clk);
    if8.start = 1'b1;
    if8.a     = 8'd5;
    if8.b     = 8'd3;
    @(negedge clk);
    if8.a = 8'd3;
    if8.b = 8'd5;
    n = 0;
    t = 0;
    td[0] = -1; td[1] = -1;
    rd[0] = 8'h00; rd[1] = 8'h00;
    rb[0] = 1'b0;  rb[1] = 1'b0;
    while (n < 2 && t < 40) begin
      if (if8.done) begin
        td[n] = t;
        rd[n] = if8.diff;
        rb[n] = if8.bor;
        n++;
        if (n == 2) if8.start = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    if8.start = 1'b0;
    check("b2b_first_done", td[0], 32'd8);
    check("b2b_spacing", td[1] - td[0], 32'd9);
    check("b2b_diff0", {24'd0, rd[0]}, 32'h02);
    check("b2b_bor0",  {31'd0, rb[0]}, 32'd0);
    check("b2b_diff1", {24'd0, rd[1]}, 32'hFE);
    check("b2b_bor1",  {31'd0, rb[1]}, 32'd1);
    repeat (3) @(negedge clk);
    check("b2b_idle_after", {30'd0, if8.busy, if8.done}, 32'd0);

    // 16-bit build
    if16.start = 1'b1;
    if16.a     = 16'h8000;
    if16.b     = 16'h0001;
    @(negedge clk);
    if16.start = 1'b0;
    if16.a     = 16'h0000;
    if16.b     = 16'hFFFF;
    lat      = 0;
    busy_cnt = 0;
    while (!if16.done && lat < 60) begin
      if (if16.busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check("w16_latency", lat, 32'd16);
    check("w16_busy_cycles", busy_cnt, 32'd16);
    check("w16_diff", {16'd0, if16.diff}, 32'h7FFF);
    check("w16_bor",  {31'd0, if16.bor},  32'd0);
    @(negedge clk);
    check("w16_done_one_cycle", {31'd0, if16.done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
